// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH product.
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   reset     synchronous active-high reset
//   run_i     level start request (debounced Run button)
//   load_i    load request: B <= sw_i, A and X cleared (IDLE only)
//   signed_i  1 = two's-complement multiply, 0 = unsigned; sampled at start
//   sw_i      switch value: load source for B, multiplicand S at start
//   aval_o    register A (upper product half)
//   bval_o    register B (lower product half / multiplier)
//   x_o       register X (product sign in signed mode, carry in unsigned mode)
//   busy_o    high while a multiply is in progress (CLR/ADD/SHIFT)
//   done_o    high in DONE while the product is valid and run_i is held
module mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
    input  logic             load_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] aval_o,
    output logic [WIDTH-1:0] bval_o,
    output logic             x_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StAdd,
        StShift,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             m_q, m_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             last_bit;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH:0]   sum;

    // Final multiplier bit: in signed mode it carries negative weight.
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // Load has priority; a held run is taken on a later cycle.
                if (!load_i && run_i) begin
                    state_d = StClr;
                end
            end
            StClr:   state_d = StAdd;
            StAdd:   state_d = StShift;
            StShift: state_d = last_bit ? StDone : StAdd;
            StDone: begin
                if (!run_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (straight from state, no input paths)
    // ------------------------------------------------------------------
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            StClr, StAdd, StShift: busy_o = 1'b1;
            StDone:                done_o = 1'b1;
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        a_ext = m_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
        s_ext = m_q ? {s_q[WIDTH-1], s_q} : {1'b0, s_q};
        sum   = (m_q && last_bit) ? (a_ext - s_ext) : (a_ext + s_ext);
    end

    always_comb begin
        x_d   = x_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        m_d   = m_q;
        cnt_d = cnt_q;
        case (state_q)
            StIdle: begin
                if (load_i) begin
                    b_d = sw_i;
                    a_d = '0;
                    x_d = 1'b0;
                end else if (run_i) begin
                    s_d   = sw_i;
                    m_d   = signed_i;
                    cnt_d = '0;
                end
            end
            StClr: begin
                a_d = '0;
                x_d = 1'b0;
            end
            StAdd: begin
                if (b_q[0]) begin
                    {x_d, a_d} = sum;
                end
            end
            StShift: begin
                // Arithmetic shift in signed mode, logical in unsigned mode.
                x_d   = m_q ? x_q : 1'b0;
                a_d   = {x_q, a_q[WIDTH-1:1]};
                b_d   = {a_q[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q + CntW'(1);
            end
            default: begin
                x_d = x_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            m_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

    assign aval_o = a_q;
    assign bval_o = b_q;
    assign x_o    = x_q;

endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised sequential shift-add multiplier, the next generation of the Lab 4 8-bit serial multiplier datapath and controller. It multiplies a multiplicand sampled from the switches (S) by the value held in register B, leaving a 2·WIDTH-bit product in {A,B} with sign/carry bit X. It adds a WIDTH parameter, a per-run signed/unsigned mode, latched operands and explicit busy/done status. The top level instantiates it between the debounced button/switch inputs and the hex/LED display drivers.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- run_i  input  1  level start request from the debounced Run button.
- load_i  input  1  load request: B <= sw_i, clear A and X.
- signed_i  input  1  1 = two's-complement multiply, 0 = unsigned; sampled at start.
- sw_i  input  WIDTH  switch value; the load source for B and the multiplicand S at start.
- aval_o  output  WIDTH  register A (upper product half).
- bval_o  output  WIDTH  register B (lower product half / multiplier).
- x_o  output  1  register X (sign bit in signed mode, carry in unsigned mode); drives sign_LED.
- busy_o  output  1  high while a multiply is in progress.
- done_o  output  1  high in DONE while the product is valid and run_i is still held.

## Operation
- Registers: X (1 bit), A, B, S (WIDTH bits each); mode bit M_s; bit counter CNT (clog2(WIDTH)+1 bits).
- FSM states: IDLE, CLR, ADD, SHIFT, DONE.
- IDLE: load_i=1 sets B <= sw_i, A <= 0, X <= 0. Otherwise run_i=1 sets S <= sw_i, M_s <= signed_i, CNT <= 0, and moves to CLR. If load_i and run_i are both 1, load wins; run is taken on the next cycle if it is still high.
- CLR: A <= 0, X <= 0, then go to ADD. B keeps its value, so a repeated run multiplies the previous low product by the new S.
- ADD: if B[0]=1, compute {X,A} <= ext(A) ± ext(S). Otherwise leave {X,A} unchanged. Then go to SHIFT.
  - Signed mode: ext is sign-extension to WIDTH+1 bits. The operation is subtract when CNT = WIDTH-1 and add otherwise.
  - Unsigned mode: ext is zero-extension, the operation is always add, and X is the carry out.
- SHIFT: {X,A,B} >> 1. The vacated X is X in signed mode and 0 in unsigned mode. CNT <= CNT+1. Go to DONE if CNT = WIDTH-1 (before the increment), else go to ADD.
- DONE: the product is {A,B} with x_o valid. Stay in DONE while run_i=1; go to IDLE when run_i=0. load_i is ignored.
- load_i and changes to sw_i or signed_i are ignored in every state except IDLE.
- All arithmetic is modulo 2^(WIDTH+1) on {X,A}, and the product never overflows 2·WIDTH bits.
  - Signed mode: X equals the product sign.
  - Unsigned mode: X = 0 at DONE.
- reset in any state, including mid-multiply: X, A, B, S, CNT <= 0, M_s <= 0, state <= IDLE. The partial product is discarded.

## Timing
- Reset values: aval_o=0, bval_o=0, x_o=0, busy_o=0, done_o=0.
- Outputs are registered or decoded directly from state (busy_o = state ∈ {CLR, ADD, SHIFT}), with no combinational path from inputs.
- run_i is sampled high in IDLE at edge T. busy_o is high from T+1 for exactly 1+2·WIDTH cycles; for WIDTH=8 that is 17 cycles.
- done_o rises at T+2+2·WIDTH and holds until the cycle after run_i is sampled low.
- A new multiply needs run_i low for at least one edge. Holding run_i never retriggers.
- A load takes effect on aval_o/bval_o/x_o one cycle after load_i is sampled in IDLE.

## Test plan
- WIDTH=8: reset, load_i with sw_i=0x07, then run_i with sw_i=0xC5, signed_i=1 -> busy_o high 17 cycles, then done_o=1, aval_o=0xFE, bval_o=0x63, x_o=1.
- Release run_i, then re-press it with sw_i=0xC5, signed_i=1 and no load -> product 0xE92F (aval_o=0xE9, bval_o=0x2F), x_o=1.
- Load B=0xFF, run with S=0xFF: signed_i=0 -> 0xFE01 with x_o=0; repeat with a fresh load and signed_i=1 -> 0x0001 with x_o=0.
- Assert reset on the 6th busy cycle -> next cycle all outputs are 0 and the FSM is in IDLE. A following load_i with sw_i=0x03 gives bval_o=0x03.
- load_i and run_i high in the same IDLE cycle, and load_i pulsed while busy -> B takes the value from the first load only, the multiply starts one cycle later, and the mid-run load has no effect.
- WIDTH=4 instance: unsigned 0xF×0xF -> aval_o=0xE, bval_o=0x1; signed 0x8×0x8 -> aval_o=0x4, bval_o=0x0, x_o=0; busy_o high 9 cycles.
